// File: rtl/apb4_completer_regfile.sv
// APB4 completer backing NUM_REGS registers, with strobes, protection check, read-only mask and wait states.
// pready/prdata/pslverr are registered and raised WAIT_STATES+1 cycles after the first ACCESS cycle.
module apb4_completer_regfile #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter bit PRIV_WR_ONLY = 1'b0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic [2:0]                     pprot,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

  state_t                               state_q;
  logic [3:0]                           cnt_q;
  logic [ADDR_WIDTH-1:0]                addr_q;
  logic                                 wr_q;
  logic [DATA_WIDTH-1:0]                wdata_q;
  logic [NB-1:0]                        strb_q;
  logic                                 priv_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q;

  logic [ADDR_WIDTH:0]   word_d;
  logic [IW-1:0]         idx_d;
  logic                  misalign_d;
  logic                  range_err_d;
  logic                  err_d;
  logic                  done_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  unused_prot;

  assign reg_q = regs_q;
  assign unused_prot = ^pprot[2:1];

  // Decode works on the captured SETUP fields, so the bus may change freely afterwards.
  always_comb begin
    word_d      = {1'b0, addr_q} >> OFFW;
    idx_d       = word_d[IW-1:0];
    misalign_d  = (addr_q & ADDR_WIDTH'(NB - 1)) != '0;
    range_err_d = word_d >= (ADDR_WIDTH + 1)'(NUM_REGS);
    err_d       = misalign_d || range_err_d
                  || (wr_q && !range_err_d && RO_MASK[idx_d])
                  || (wr_q && PRIV_WR_ONLY && !priv_q);
    rdata_d     = (wr_q || err_d) ? '0 : regs_q[idx_d];
    done_d      = (state_q == SETUP && WAIT_STATES == 0)
                  || (state_q == WAIT && psel && penable && cnt_q == LAST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
      priv_q       <= 1'b0;
      regs_q       <= RESET_VAL;
      pready       <= 1'b0;
      pslverr      <= 1'b0;
      prdata       <= '0;
      reg_wr_pulse <= '0;
    end else begin
      pready       <= 1'b0;
      pslverr      <= 1'b0;
      prdata       <= '0;
      reg_wr_pulse <= '0;
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            addr_q  <= paddr;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            priv_q  <= pprot[0];
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (!done_d) begin
            state_q <= WAIT;
            cnt_q   <= '0;
          end
        end
        WAIT: begin
          if (!psel || !penable) state_q <= IDLE;
          else if (!done_d) cnt_q <= cnt_q + 4'd1;
        end
        DONE: begin
          state_q <= IDLE;
          // Commit only if the requester held the transfer through the completion edge.
          if (psel && penable && wr_q && !err_d) begin
            for (int b = 0; b < NB; b++) begin
              if (strb_q[b]) regs_q[idx_d][8*b +: 8] <= wdata_q[8*b +: 8];
            end
            reg_wr_pulse[idx_d] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (done_d) begin
        state_q <= DONE;
        pready  <= 1'b1;
        pslverr <= err_d;
        prdata  <= rdata_d;
      end
    end
  end
endmodule

// File: tb/tb_apb4_completer_regfile.sv
// Directed bench: three completer instances (0, 3 and 5 wait states) on a shared APB bus.
module tb_apb4_completer_regfile;
  localparam logic [511:0] RV = (512'h12345678 << 32) | (512'h33333333 << 96);

  logic        clk, reset, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  int          sel;

  logic          pready_a, pready_b, pready_c, pslverr_a, pslverr_b, pslverr_c;
  logic [31:0]   prdata_a, prdata_b, prdata_c;
  logic [511:0]  regq_a, regq_b, regq_c;
  logic [15:0]   pulse_a, pulse_b, pulse_c;
  logic          m_pready, m_pslverr;
  logic [31:0]   m_prdata;

  int checks = 0;
  int failures = 0;

  apb4_completer_regfile #(.WAIT_STATES(0), .RO_MASK(16'h0008), .RESET_VAL(RV)) u_a (
    .clk(clk), .reset(reset), .psel(psel && sel == 0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready_a),
    .prdata(prdata_a), .pslverr(pslverr_a), .reg_q(regq_a), .reg_wr_pulse(pulse_a));
  apb4_completer_regfile #(.WAIT_STATES(3), .RO_MASK(16'h0008), .RESET_VAL(RV)) u_b (
    .clk(clk), .reset(reset), .psel(psel && sel == 1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready_b),
    .prdata(prdata_b), .pslverr(pslverr_b), .reg_q(regq_b), .reg_wr_pulse(pulse_b));
  apb4_completer_regfile #(.WAIT_STATES(5), .PRIV_WR_ONLY(1'b1), .RESET_VAL(RV)) u_c (
    .clk(clk), .reset(reset), .psel(psel && sel == 2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready_c),
    .prdata(prdata_c), .pslverr(pslverr_c), .reg_q(regq_c), .reg_wr_pulse(pulse_c));

  always_comb begin
    m_pready = pready_a; m_pslverr = pslverr_a; m_prdata = prdata_a;
    if (sel == 1) begin m_pready = pready_b; m_pslverr = pslverr_b; m_prdata = prdata_b; end
    if (sel == 2) begin m_pready = pready_c; m_pslverr = pslverr_c; m_prdata = prdata_c; end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transfer; returns read data, error flag and number of ACCESS cycles with pready low.
  task automatic xfer(input int d, input logic w, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er, output int lows);
    logic seen;
    sel = d; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = s; pprot = pr;
    @(posedge clk); #1 penable = 1'b1;
    lows = 0; seen = 1'b0; rd = 'x; er = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_pready) begin rd = m_prdata; er = m_pslverr; seen = 1'b1; break; end
      lows++;
    end
    chk("xfer_timeout", {511'd0, seen}, 512'd1);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lows;
  logic [511:0] ea, ec;
  logic        saw_rdy, saw_pulse;

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; pprot = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_pready", {pready_a, pready_b, pready_c}, 0);
    chk("rst_pslverr", {pslverr_a, pslverr_b, pslverr_c}, 0);
    chk("rst_prdata", {prdata_a, prdata_b, prdata_c}, 0);
    chk("rst_pulse", {pulse_a, pulse_b, pulse_c}, 0);
    chk("rst_regq_a", regq_a, RV);
    chk("rst_regq_c", regq_c, RV);
    ea = RV; ec = RV;

    // Basic write/read, zero wait states
    xfer(0, 1, 12'h008, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, lows);
    chk("wr08_lows", lows, 1);
    chk("wr08_err", er, 0);
    chk("wr08_pulse", pulse_a, 16'h0004);
    ea[95:64] = 32'hDEADBEEF;
    chk("wr08_regq", regq_a, ea);
    @(posedge clk); #1;
    chk("wr08_pulse_end", pulse_a, 0);
    xfer(0, 0, 12'h008, 32'h0, 4'h0, 3'b000, rd, er, lows);
    chk("rd08_data", rd, 32'hDEADBEEF);
    chk("rd08_err", er, 0);
    chk("rd08_lows", lows, 1);
    chk("rd08_prdata_idle", prdata_a, 0);

    // Three wait states
    xfer(1, 0, 12'h004, 32'h0, 4'h0, 3'b000, rd, er, lows);
    chk("ws3_lows", lows, 4);
    chk("ws3_data", rd, 32'h12345678);
    chk("ws3_err", er, 0);

    // Partial strobes
    xfer(0, 1, 12'h004, 32'h11223344, 4'hF, 3'b000, rd, er, lows);
    xfer(0, 1, 12'h004, 32'hAABBCCDD, 4'b0101, 3'b000, rd, er, lows);
    chk("strb_word1", regq_a[63:32], 32'h11BB33DD);
    ea[63:32] = 32'h11BB33DD;
    xfer(0, 1, 12'h000, 32'h99999999, 4'h0, 3'b000, rd, er, lows);
    chk("strb0_err", er, 0);
    chk("strb0_pulse", pulse_a, 16'h0001);
    chk("strb0_regq", regq_a, ea);

    // Error cases
    xfer(0, 1, 12'h040, 32'h01010101, 4'hF, 3'b000, rd, er, lows);
    chk("oor_err", er, 1);
    chk("oor_pulse", pulse_a, 0);
    chk("oor_regq", regq_a, ea);
    xfer(0, 1, 12'h006, 32'h02020202, 4'hF, 3'b000, rd, er, lows);
    chk("mis_err", er, 1);
    chk("mis_regq", regq_a, ea);
    xfer(0, 1, 12'h00C, 32'h03030303, 4'hF, 3'b000, rd, er, lows);
    chk("ro_err", er, 1);
    chk("ro_regq", regq_a, ea);
    xfer(0, 0, 12'h00C, 32'h0, 4'h0, 3'b000, rd, er, lows);
    chk("ro_rd_err", er, 0);
    chk("ro_rd_data", rd, 32'h33333333);
    xfer(0, 0, 12'h040, 32'h0, 4'h0, 3'b000, rd, er, lows);
    chk("oor_rd_err", er, 1);
    chk("oor_rd_data", rd, 0);

    // Privilege check, five wait states
    xfer(2, 1, 12'h010, 32'h0BADBAD0, 4'hF, 3'b000, rd, er, lows);
    chk("priv0_err", er, 1);
    chk("priv0_lows", lows, 6);
    chk("priv0_regq", regq_c, ec);
    xfer(2, 1, 12'h010, 32'hCAFEF00D, 4'hF, 3'b001, rd, er, lows);
    chk("priv1_err", er, 0);
    ec[159:128] = 32'hCAFEF00D;
    chk("priv1_regq", regq_c, ec);

    // Abort during WAIT, then an immediate read
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014;
    pwdata = 32'h55555555; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_pready", pready_b, 0);
    @(posedge clk); #1;
    chk("abort_regq", regq_b, RV);
    chk("abort_pulse", pulse_b, 0);
    xfer(1, 0, 12'h014, 32'h0, 4'h0, 3'b000, rd, er, lows);
    chk("abort_rd_data", rd, 0);
    chk("abort_rd_err", er, 0);
    chk("abort_rd_lows", lows, 4);

    // Reset on the second wait cycle of a five-wait write
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010;
    pwdata = 32'h0; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mrst_pready_pre", pready_c, 0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; psel = 1'b0; penable = 1'b0;
    chk("mrst_regq", regq_c, RV);
    saw_rdy = 1'b0; saw_pulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_rdy = saw_rdy | pready_c;
      saw_pulse = saw_pulse | (|pulse_c);
    end
    chk("mrst_no_pready", {511'd0, saw_rdy}, 0);
    chk("mrst_no_pulse", {511'd0, saw_pulse}, 0);
    chk("mrst_regq_after", regq_c, RV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
